// File: rtl/decoder_2to4.sv
// ----------------------------------------------------------------------------
// decoder_2to4
//   Registered binary-to-one-hot decoder with enable, valid qualifier and a
//   sticky coverage mask. Default: 2 select bits -> 4 outputs.
//   Legacy mapping: sel[0] = inp1, sel[1] = inp2; dout[k] = out(k+1).
//
// Parameters:
//   SEL_W      - number of select bits (1..5); output width is 2**SEL_W
//   ACTIVE_LOW - 1 inverts dout (selected bit 0, idle bits 1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   sel        in   binary index
//   en         in   decode enable (en=0 forces dout idle, wins over in_valid)
//   in_valid   in   sel is meaningful this cycle
//   clr_seen   in   synchronous clear of the seen mask
//   dout       out  registered one-hot decode
//   out_valid  out  dout holds a fresh decode
//   seen       out  sticky mask of decoded bits, always active-high
//   onehot_err out  (only with DECODER_ONEHOT_CHECK_EN) sticky one-hot error
//
// Optional feature macro: DECODER_ONEHOT_CHECK_EN
// ----------------------------------------------------------------------------
module decoder_2to4 #(
   parameter int unsigned SEL_W      = 2,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic                    clr_seen,
   output logic [(1<<SEL_W)-1:0]   dout,
   output logic                    out_valid,
`ifdef DECODER_ONEHOT_CHECK_EN
   output logic [(1<<SEL_W)-1:0]   seen,
   output logic                    onehot_err
`else
   output logic [(1<<SEL_W)-1:0]   seen
`endif
);

   localparam int unsigned        OUT_W = 1 << SEL_W;
   localparam logic [OUT_W-1:0]   IDLE  = ACTIVE_LOW ? '1 : '0;

   logic [OUT_W-1:0] r_dout;
   logic             r_valid;
   logic [OUT_W-1:0] r_seen;
   logic [OUT_W-1:0] w_onehot;
   logic             w_capture;

   assign w_onehot  = OUT_W'(1) << sel;
   assign w_capture = en & in_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout  <= IDLE;
         r_valid <= 1'b0;
         r_seen  <= '0;
      end else begin
         if (!en) begin
            r_dout  <= IDLE;
            r_valid <= 1'b0;
         end else if (in_valid) begin
            // dout is stored already polarity-adjusted so it leaves a flop directly
            r_dout  <= w_onehot ^ IDLE;
            r_valid <= 1'b1;
         end else begin
            r_valid <= 1'b0;
         end

         // a capture on the clearing edge survives the clear
         if (clr_seen)
            r_seen <= w_capture ? w_onehot : '0;
         else if (w_capture)
            r_seen <= r_seen | w_onehot;
      end
   end

   assign dout      = r_dout;
   assign out_valid = r_valid;
   assign seen      = r_seen;

`ifdef DECODER_ONEHOT_CHECK_EN
   logic [OUT_W-1:0] w_dout_ah;
   logic             w_multi;
   logic             r_err;

   assign w_dout_ah = r_dout ^ IDLE;
   // more than one bit set <=> clearing the lowest set bit leaves something
   assign w_multi   = |(w_dout_ah & (w_dout_ah - OUT_W'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else if (w_multi)
         r_err <= 1'b1;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && w_multi && !r_err)
         $error("decoder_2to4: dout not one-hot: %b", w_dout_ah);
   end
`endif

   assign onehot_err = r_err;
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
module tb_decoder_2to4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sel;
   logic       en, in_valid, clr_seen;
   logic [3:0] dout, seen, dout_al, seen_al;
   logic       out_valid, valid_al;
`ifdef DECODER_ONEHOT_CHECK_EN
   logic       err_ah, err_al;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state (active-high)
   logic [3:0] m_dout, m_seen;
   logic       m_valid;

   always #5 clk = ~clk;

   decoder_2to4 #(.SEL_W(2), .ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .rst(rst), .sel(sel), .en(en), .in_valid(in_valid),
      .clr_seen(clr_seen), .dout(dout), .out_valid(out_valid),
`ifdef DECODER_ONEHOT_CHECK_EN
      .seen(seen), .onehot_err(err_ah)
`else
      .seen(seen)
`endif
   );

   decoder_2to4 #(.SEL_W(2), .ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rst(rst), .sel(sel), .en(en), .in_valid(in_valid),
      .clr_seen(clr_seen), .dout(dout_al), .out_valid(valid_al),
`ifdef DECODER_ONEHOT_CHECK_EN
      .seen(seen_al), .onehot_err(err_al)
`else
      .seen(seen_al)
`endif
   );

   task automatic model_reset();
      m_dout  = 4'b0000;
      m_valid = 1'b0;
      m_seen  = 4'b0000;
   endtask

   // one clock edge: model consumes the inputs present at the edge
   task automatic tick();
      logic [3:0] oh;
      logic       cap;
      @(posedge clk);
      oh  = 4'(2 ** int'(sel));
      cap = en && in_valid;
      if (!en) begin
         m_dout = 4'b0000; m_valid = 1'b0;
      end else if (in_valid) begin
         m_dout = oh; m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (clr_seen) m_seen = cap ? oh : 4'b0000;
      else if (cap) m_seen = m_seen | oh;
      #1;
   endtask

   task automatic test_reset();
      en = 1'b1; in_valid = 1'b1; clr_seen = 1'b0; sel = 2'b11;
      rst = 1'b1; #2; rst = 1'b0;
      model_reset();
      tick();                            // dout now 1000
      #2; rst = 1'b1; #1;                // no clock edge in between
      model_reset();
      n_checks++;
      if ({dout, out_valid, seen} !== {4'b0000, 1'b0, 4'b0000})
         $display("FAIL reset_ah: got dout=%b v=%b seen=%b want 0000/0/0000", dout, out_valid, seen);
      else n_pass++;
      n_checks++;
      if ({dout_al, valid_al, seen_al} !== {4'b1111, 1'b0, 4'b0000})
         $display("FAIL reset_al: got dout=%b v=%b seen=%b want 1111/0/0000", dout_al, valid_al, seen_al);
      else n_pass++;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_sweep();
      en = 1'b1; in_valid = 1'b1; clr_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         tick();
         n_checks++;
         if ({dout, out_valid, dout_al} !== {4'(1 << i), 1'b1, ~4'(1 << i)})
            $display("FAIL sweep_%0d: got dout=%b v=%b dout_al=%b want %b/1/%b",
                     i, dout, out_valid, dout_al, 4'(1 << i), ~4'(1 << i));
         else n_pass++;
      end
      n_checks++;
      if ({seen, seen_al} !== {4'b1111, 4'b1111})
         $display("FAIL sweep_seen: got %b/%b want 1111/1111", seen, seen_al);
      else n_pass++;
   endtask

   task automatic test_seen_clear();
      // seen is 1111 from the sweep
      sel = 2'b01; en = 1'b1; in_valid = 1'b1; clr_seen = 1'b1;
      tick();
      clr_seen = 1'b0;
      n_checks++;
      if ({seen, seen_al, dout, dout_al} !== {4'b0010, 4'b0010, 4'b0010, 4'b1101})
         $display("FAIL seen_clear: got seen=%b seen_al=%b dout=%b dout_al=%b want 0010/0010/0010/1101",
                  seen, seen_al, dout, dout_al);
      else n_pass++;
      clr_seen = 1'b1; in_valid = 1'b0;
      tick();
      clr_seen = 1'b0;
      n_checks++;
      if (seen !== 4'b0000)
         $display("FAIL seen_clear_only: got %b want 0000", seen);
      else n_pass++;
   endtask

   task automatic test_hold_enable();
      en = 1'b1; in_valid = 1'b1; sel = 2'b10;
      tick();
      in_valid = 1'b0; sel = 2'b11;
      tick();
      n_checks++;
      if ({dout, out_valid, dout_al, valid_al} !== {4'b0100, 1'b0, 4'b1011, 1'b0})
         $display("FAIL hold: got dout=%b v=%b dout_al=%b want 0100/0/1011", dout, out_valid, dout_al);
      else n_pass++;
      en = 1'b0; in_valid = 1'b1;
      tick();
      n_checks++;
      if ({dout, out_valid, dout_al} !== {4'b0000, 1'b0, 4'b1111})
         $display("FAIL enable_off: got dout=%b v=%b dout_al=%b want 0000/0/1111", dout, out_valid, dout_al);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      en = 1'b1; in_valid = 1'b1; sel = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({dout, out_valid} !== {4'b0100, 1'b1})
            $display("FAIL b2b_%0d: got dout=%b v=%b want 0100/1", i, dout, out_valid);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if (dout !== 4'b0100)
            $display("FAIL b2b_mid_%0d: got dout=%b want 0100", i, dout);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      en = 1'b1; in_valid = 1'b1; sel = 2'b11;
      tick();
      n_checks++;
      if (dout !== 4'b1000)
         $display("FAIL pre_reset: got dout=%b want 1000", dout);
      else n_pass++;
      #3; rst = 1'b1; #1;
      model_reset();
      n_checks++;
      if ({dout, out_valid, seen, dout_al, valid_al, seen_al} !==
          {4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000})
         $display("FAIL async_reset: got %b/%b/%b al %b/%b/%b want 0000/0/0000 al 1111/0/0000",
                  dout, out_valid, seen, dout_al, valid_al, seen_al);
      else n_pass++;
      @(negedge clk); rst = 1'b0;
      sel = 2'b01;
      tick();
      n_checks++;
      if ({dout, out_valid, seen} !== {4'b0010, 1'b1, 4'b0010})
         $display("FAIL resume: got dout=%b v=%b seen=%b want 0010/1/0010", dout, out_valid, seen);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         en       = ($urandom_range(0, 7) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         clr_seen = ($urandom_range(0, 15) == 0);
         sel      = 2'($urandom_range(0, 3));
         tick();
         n_checks++;
         if ({dout, out_valid, seen, dout_al, valid_al, seen_al} !==
             {m_dout, m_valid, m_seen, ~m_dout, m_valid, m_seen})
            $display("FAIL random_%0d: got %b/%b/%b al %b/%b/%b want %b/%b/%b al %b/%b/%b", i,
                     dout, out_valid, seen, dout_al, valid_al, seen_al,
                     m_dout, m_valid, m_seen, ~m_dout, m_valid, m_seen);
         else n_pass++;
`ifdef DECODER_ONEHOT_CHECK_EN
         n_checks++;
         if ({err_ah, err_al} !== 2'b00)
            $display("FAIL onehot_err_%0d: got %b/%b want 0/0", i, err_ah, err_al);
         else n_pass++;
`endif
      end
      clr_seen = 1'b0;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; in_valid = 1'b0; clr_seen = 1'b0; sel = 2'b00;
      model_reset();
      test_reset();
      test_sweep();
      test_seen_clear();
      test_hold_enable();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/decoder_2to4.md
Name: decoder_2to4

Overview:
- Registered binary-to-one-hot decoder, default 2 select bits to 4 outputs.
- Used wherever a small binary index must drive one-of-N enables: chip selects, mux controls, status LEDs.
- Select bit 0 corresponds to the legacy input "inp1" and bit 1 to "inp2". Output bit k corresponds to legacy output "out(k+1)".
- Adds an enable, a valid qualifier, and a sticky coverage mask on top of the plain decode.

Parameters:
- SEL_W, 2, number of select bits; output width is 2**SEL_W (legal range 1..5).
- ACTIVE_LOW, 0, when 1 the decoded output and idle levels are inverted (selected bit 0, others 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- sel  input  SEL_W  binary index; bit 0 = inp1 (LSB), bit 1 = inp2
- en  input  1  decode enable
- in_valid  input  1  sel is meaningful this cycle
- clr_seen  input  1  synchronous clear of the seen mask
- dout  output  2**SEL_W  one-hot decode; bit k asserted when the registered sel equals k
- out_valid  output  1  dout holds a fresh decode
- seen  output  2**SEL_W  sticky mask of every output bit asserted since the last reset or clear

Behaviour:
- Reset (rst=1, asynchronous, any time):
  - dout = all-inactive (all 0, or all 1 if ACTIVE_LOW).
  - out_valid = 0.
  - seen = 0.
  - Reset mid-operation discards any pending decode immediately.
- Decode function (active-high case): dout[k] = 1 iff sel == k, else 0. Exactly one bit is high when decoding.
- Default 2-bit mapping with sel = {inp2, inp1}:
  - 00 -> 0001
  - 01 -> 0010
  - 10 -> 0100
  - 11 -> 1000
- Latency: 1 clock. On a rising edge with en=1 and in_valid=1, dout takes decode(sel) and out_valid=1 on the following cycle.
- en=1, in_valid=0: dout holds its previous value; out_valid=0.
- en=0: dout forced to all-inactive at the next edge; out_valid=0. This takes precedence over in_valid.
- ACTIVE_LOW=1: dout is the bitwise inverse of the active-high result, including the idle state. seen and out_valid are never inverted.
- Seen mask:
  - At each edge where a decode is captured, seen |= onehot(sel), always in active-high form.
  - clr_seen=1 clears seen at the edge.
  - If clr_seen and a capture occur on the same edge, seen = onehot(sel) of that capture.
- Unchanged sel with repeated valid captures: dout stays stable, with no glitch cycle.
- All outputs are driven from flops; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: DECODER_ONEHOT_CHECK_EN.
- Defined:
  - Adds output port onehot_err (1 bit), registered.
  - onehot_err is set sticky when the active-high form of dout is neither all-zero nor exactly one bit set.
  - Cleared only by rst.
  - For simulation, an $error message is also issued on the set event.
- Undefined: the port and its logic are absent; functionality is otherwise identical.

Test Plan:
- Reset: assert rst with en=1, sel=11 -> dout=0000, out_valid=0, seen=0000 immediately, without waiting for a clock.
- Full sweep: en=1, in_valid=1, sel=00,01,10,11 on consecutive edges -> dout=0001,0010,0100,1000, each one cycle later; out_valid=1 throughout; seen=1111 at the end.
- Hold/enable: capture sel=10 (dout=0100), then in_valid=0 with sel=11 -> dout stays 0100 and out_valid=0. Then en=0 -> dout=0000 at the next edge.
- Seen clear: seen=1111, then clr_seen=1 with a simultaneous capture of sel=01 -> seen=0010.
- ACTIVE_LOW=1 build: sel=01 captured -> dout=1101; after reset, dout=1111; seen=0010 after the capture.
- Async reset mid-stream: rst pulsed between edges while dout=1000 -> all outputs cleared at once; decoding resumes normally after release.
